fft_frame_deserializer: RTL and testbench

FFT_FRAME_DESERIALIZER -- requirements
Module: fft_frame_deserializer

---
 rtl/fft_frame_deserializer.sv | 152 +++++++++++++++
 tb/tb_fft_frame_deserializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_deserializer.sv
// Assembles a little-endian stream of UART bytes into one FFT frame of
// FFT_SIZE words. Tracks frame completion, overrun while the held frame is
// unacknowledged, inter-byte timeout and receive-error discard.
module fft_frame_deserializer #(
    parameter int FFT_SIZE       = 16,
    parameter int WORD_SIZE      = 16,
    parameter int DATA_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_LENGTH-1:0]        i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_rx_error,
    input  logic                          i_frame_ack,
    output logic [FFT_SIZE*WORD_SIZE-1:0] o_frame,
    output logic                          o_frame_valid,
    output logic [5:0]                    o_byte_count,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic                          o_timeout,
    output logic                          o_err_drop
);

    localparam int FRAME_W = FFT_SIZE * WORD_SIZE;
    localparam int POS_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [5:0]       LAST_IDX = 6'(2 * FFT_SIZE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;

    logic             accept;
    logic [5:0]       acc_idx;
    logic             acc_last;
    logic [POS_W-1:0] wr_pos;

    // Decide whether this cycle's byte is taken and where it lands in the frame.
    // A byte that starts a frame (from IDLE, or together with the ack in FULL)
    // always goes to index 0; an rx error in COLLECT beats a coincident byte.
    always_comb begin
        accept  = 1'b0;
        acc_idx = o_byte_count;
        unique case (state)
            IDLE: begin
                accept  = i_byte_valid && !i_rx_error;
                acc_idx = 6'd0;
            end
            COLLECT: begin
                accept  = i_byte_valid && !i_rx_error;
            end
            FULL: begin
                accept  = i_byte_valid && i_frame_ack;
                acc_idx = 6'd0;
            end
            default: begin
                accept  = 1'b0;
            end
        endcase
        // Even byte -> low half of word idx/2, odd byte -> high half.
        wr_pos   = POS_W'(int'(acc_idx[5:1]) * WORD_SIZE + int'(acc_idx[0]) * DATA_LENGTH);
        acc_last = (acc_idx == LAST_IDX);
    end

    // Word storage: only an accepted byte writes; discards leave old contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame <= '0;
        end else if (accept) begin
            o_frame[wr_pos +: DATA_LENGTH] <= i_byte;
        end
    end

    // Frame FSM with registered status outputs and the inter-byte timer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            timer         <= '0;
            o_byte_count  <= 6'd0;
            o_frame_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
            o_timeout     <= 1'b0;
            o_err_drop    <= 1'b0;
        end else begin
            o_timeout  <= 1'b0;
            o_err_drop <= 1'b0;

            unique case (state)
                IDLE: begin
                    timer <= '0;
                end
                COLLECT: begin
                    if (i_rx_error) begin
                        state        <= IDLE;
                        timer        <= '0;
                        o_byte_count <= 6'd0;
                        o_busy       <= 1'b0;
                        o_err_drop   <= 1'b0 | 1'b1;
                    end else if (!i_byte_valid && timer == TMR_LAST) begin
                        state        <= IDLE;
                        timer        <= '0;
                        o_byte_count <= 6'd0;
                        o_busy       <= 1'b0;
                        o_timeout    <= 1'b1;
                    end else if (!i_byte_valid) begin
                        timer <= timer + 1'b1;
                    end
                end
                FULL: begin
                    if (i_frame_ack) begin
                        state         <= IDLE;
                        o_frame_valid <= 1'b0;
                        o_overrun     <= 1'b0;
                        o_busy        <= 1'b0;
                    end else if (i_byte_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            // An accepted byte overrides the transitions above.
            if (accept) begin
                timer <= '0;
                if (acc_last) begin
                    state         <= FULL;
                    o_byte_count  <= 6'd0;
                    o_frame_valid <= 1'b1;
                    o_busy        <= 1'b1;
                end else begin
                    state         <= COLLECT;
                    o_byte_count  <= acc_idx + 6'd1;
                    o_frame_valid <= 1'b0;
                    o_busy        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_deserializer.sv
// Self-checking bench for fft_frame_deserializer: a table of single-cycle
// vectors, directed multi-cycle sequences and a randomized run against a
// queue-based frame model.
module tb_fft_frame_deserializer;

    localparam int FFT_SIZE = 16;
    localparam int NBYTES   = 2 * FFT_SIZE;
    localparam int TMO      = 50;
    localparam int FW       = FFT_SIZE * 16;

    logic          clk;
    logic          rst;
    logic [7:0]    byte_in;
    logic          bv;
    logic          err;
    logic          ack;
    logic [FW-1:0] frame;
    logic          fv;
    logic [5:0]    cnt;
    logic          busy;
    logic          ovr;
    logic          tmo;
    logic          edrop;

    int n_checks = 0;
    int n_fail   = 0;

    fft_frame_deserializer #(
        .FFT_SIZE(FFT_SIZE), .WORD_SIZE(16), .DATA_LENGTH(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_byte(byte_in), .i_byte_valid(bv),
        .i_rx_error(err), .i_frame_ack(ack), .o_frame(frame),
        .o_frame_valid(fv), .o_byte_count(cnt), .o_busy(busy),
        .o_overrun(ovr), .o_timeout(tmo), .o_err_drop(edrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input int k);
        return frame[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bv = 1'b1;
        byte_in = b;
        tick();
        bv = 1'b0;
    endtask

    task automatic do_reset();
        bv = 1'b0; err = 1'b0; ack = 1'b0; byte_in = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // A partial frame is a queue of bytes; o_frame is a byte memory written at
    // the queue position of each accepted byte; a held frame waits for ack.
    logic [7:0] m_q[$];
    logic [7:0] m_mem[NBYTES];
    bit         m_held, m_ovr, m_tmo, m_edrop;
    int         m_sil;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
        m_held = 0; m_ovr = 0; m_tmo = 0; m_edrop = 0; m_sil = 0;
    endtask

    task automatic model_take(input logic [7:0] b);
        m_mem[m_q.size()] = b;
        m_q.push_back(b);
        m_sil = 0;
        if (m_q.size() == NBYTES) begin
            m_held = 1;
            m_q.delete();
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit e, input bit a);
        m_tmo = 0;
        m_edrop = 0;
        if (m_held) begin
            if (a) begin
                m_held = 0;
                m_ovr = 0;
                if (v) model_take(b);
            end else if (v) begin
                m_ovr = 1;
            end
        end else if (m_q.size() > 0) begin
            if (e) begin
                m_q.delete();
                m_edrop = 1;
            end else if (v) begin
                model_take(b);
            end else if (m_sil == TMO - 1) begin
                m_q.delete();
                m_tmo = 1;
            end else begin
                m_sil++;
            end
        end else if (v && !e) begin
            model_take(b);
        end
    endtask

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < NBYTES; i++) f[i*8 +: 8] = m_mem[i];
        return f;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit         v;
        logic [7:0] b;
        bit         e;
        bit         a;
        bit         x_valid;
        logic [5:0] x_cnt;
        bit         x_busy;
        bit         x_ovr;
        bit         x_tmo;
        bit         x_edrop;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [FW-1:0] saved;
        int            n;
        bit            seen;
        int            mode;
        bit            rv, re, ra;
        logic [7:0]    rb;

        tbl[0]  = '{0, 8'h00, 1, 0, 0, 6'd0, 0, 0, 0, 0};  // rx error in IDLE ignored
        tbl[1]  = '{0, 8'h00, 0, 1, 0, 6'd0, 0, 0, 0, 0};  // ack in IDLE ignored
        tbl[2]  = '{1, 8'h11, 1, 0, 0, 6'd0, 0, 0, 0, 0};  // errored byte not taken in IDLE
        tbl[3]  = '{1, 8'h22, 0, 0, 0, 6'd1, 1, 0, 0, 0};
        tbl[4]  = '{1, 8'h33, 0, 0, 0, 6'd2, 1, 0, 0, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 6'd2, 1, 0, 0, 0};
        tbl[6]  = '{0, 8'h00, 0, 1, 0, 6'd2, 1, 0, 0, 0};  // ack in COLLECT ignored
        tbl[7]  = '{1, 8'h44, 1, 0, 0, 6'd0, 0, 0, 0, 1};  // error beats byte
        tbl[8]  = '{0, 8'h00, 0, 0, 0, 6'd0, 0, 0, 0, 0};
        tbl[9]  = '{1, 8'h55, 0, 0, 0, 6'd1, 1, 0, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 0, 6'd0, 0, 0, 0, 1};
        tbl[11] = '{0, 8'h00, 0, 0, 0, 6'd0, 0, 0, 0, 0};

        // Reset state
        do_reset();
        check("reset_frame", frame, '0);
        check("reset_valid", fv, 0);
        check("reset_count", cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_ovr", ovr, 0);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            bv = tbl[i].v; byte_in = tbl[i].b; err = tbl[i].e; ack = tbl[i].a;
            tick();
            bv = 0; err = 0; ack = 0;
            check($sformatf("tbl%0d_valid", i), fv, tbl[i].x_valid);
            check($sformatf("tbl%0d_count", i), cnt, tbl[i].x_cnt);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
            check($sformatf("tbl%0d_ovr", i), ovr, tbl[i].x_ovr);
            check($sformatf("tbl%0d_tmo", i), tmo, tbl[i].x_tmo);
            check($sformatf("tbl%0d_edrop", i), edrop, tbl[i].x_edrop);
        end
        check("tbl_word0_kept", word(0), 16'h3355);

        // Full frame, one strobe every 10 cycles
        do_reset();
        for (int i = 0; i < NBYTES; i++) begin
            if (i == NBYTES - 1) check("valid_before_last", fv, 0);
            send_byte(8'(i));
            if (i == NBYTES - 1) begin
                check("frame_valid_latency", fv, 1);
                check("full_count", cnt, 0);
                check("full_busy", busy, 1);
                check("word0", word(0), 16'h0100);
                check("word1", word(1), 16'h0302);
                check("word15", word(15), 16'h1F1E);
            end else begin
                repeat (9) tick();
            end
        end

        // Overrun while held, then ack with a new first byte
        saved = frame;
        send_byte(8'hE0);
        tick();
        send_byte(8'hE1);
        check("overrun_set", ovr, 1);
        check("overrun_frame_held", frame, saved);
        check("overrun_valid_held", fv, 1);
        ack = 1;
        send_byte(8'hAA);
        ack = 0;
        check("ackbyte_ovr_clr", ovr, 0);
        check("ackbyte_count", cnt, 1);
        check("ackbyte_busy", busy, 1);
        check("ackbyte_valid", fv, 0);
        check("ackbyte_word0", word(0), 16'h01AA);

        // Timeout: 5 bytes total then silence
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        check("tmo_pre_count", cnt, 5);
        n = 0;
        seen = 0;
        while (n < 200 && !seen) begin
            tick();
            n++;
            seen = tmo;
        end
        check("tmo_latency", n, TMO);
        check("tmo_count", cnt, 0);
        check("tmo_busy", busy, 0);
        tick();
        check("tmo_single_pulse", tmo, 0);

        // Byte at expiry wins
        for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
        seen = 0;
        repeat (TMO - 1) begin
            tick();
            if (tmo) seen = 1;
        end
        send_byte(8'h66);
        if (tmo) seen = 1;
        tick();
        if (tmo) seen = 1;
        check("expiry_byte_count", cnt, 6);
        check("expiry_no_tmo", seen, 0);
        check("expiry_busy", busy, 1);
        err = 1;
        tick();
        err = 0;
        check("expiry_cleanup_edrop", edrop, 1);

        // Error drop with coincident byte, then a clean frame
        for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i));
        err = 1;
        send_byte(8'h99);
        err = 0;
        check("edrop_pulse", edrop, 1);
        check("edrop_count", cnt, 0);
        check("edrop_busy", busy, 0);
        tick();
        check("edrop_single_pulse", edrop, 0);
        for (int i = 0; i < NBYTES; i++) send_byte(8'h40 + 8'(i));
        check("after_err_valid", fv, 1);
        check("after_err_word0", word(0), 16'h4140);
        check("after_err_word15", word(15), 16'h5F5E);
        ack = 1;
        tick();
        ack = 0;
        check("ack_valid_clr", fv, 0);
        check("ack_busy_clr", busy, 0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 20; i++) send_byte(8'h70 + 8'(i));
        #3;
        rst = 1;
        #1;
        check("async_rst_frame", frame, '0);
        check("async_rst_valid", fv, 0);
        check("async_rst_count", cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_flags", {ovr, tmo, edrop}, 3'b000);
        @(posedge clk);
        #3;
        rst = 0;
        for (int i = 0; i < NBYTES; i++) send_byte(8'h80 + 8'(i));
        check("post_rst_valid", fv, 1);
        check("post_rst_word0", word(0), 16'h8180);
        check("post_rst_word15", word(15), 16'h9F9E);

        // Randomized run against the model
        do_reset();
        model_reset();
        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) mode = $urandom_range(0, 3);
            rv = (mode == 0) ? ($urandom_range(0, 99) < 1) : ($urandom_range(0, 99) < 60);
            rb = 8'($urandom);
            re = $urandom_range(0, 99) < 2;
            ra = m_held ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 5);
            bv = rv; byte_in = rb; err = re; ack = ra;
            tick();
            bv = 0; err = 0; ack = 0;
            model_step(rv, rb, re, ra);
            check("rnd_valid", fv, m_held);
            check("rnd_count", cnt, 6'(m_q.size()));
            check("rnd_busy", busy, m_held || (m_q.size() > 0));
            check("rnd_ovr", ovr, m_ovr);
            check("rnd_tmo", tmo, m_tmo);
            check("rnd_edrop", edrop, m_edrop);
            check("rnd_frame", frame, model_frame());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
